// File: rtl/freq_gate_controller_if.sv
// Result hand-off bundle between the gate controller and the display side.
//   result_digits   : latched BCD measurement, digit 0 in bits [3:0]
//   result_overflow : the counter wrapped during that measurement
//   result_valid    : result register holds an unconsumed measurement
//   result_ack      : consumer accepts the current result
// Handshake: a result is transferred in any cycle where result_valid=1 and
// result_ack=1. While result_valid=1 and result_ack=0 the producer holds
// result_digits/result_overflow stable. result_ack is ignored while
// result_valid=0.
interface freq_gate_controller_if #(
  parameter int DIGITS_NUM = 6
);
  logic [4*DIGITS_NUM-1:0] result_digits;
  logic                    result_overflow;
  logic                    result_valid;
  logic                    result_ack;

  modport master (
    output result_digits,
    output result_overflow,
    output result_valid,
    input  result_ack
  );

  modport slave (
    input  result_digits,
    input  result_overflow,
    input  result_valid,
    output result_ack
  );
endinterface

// File: rtl/freq_gate_controller.sv
// Measurement sequencer for the BCD event counter of the frequency counter.
// Each cycle: clear the counter, open a gate window of GATE_CYCLES clocks
// during which synchronized rising edges of signal_in pulse the counter
// enable, let the last increment settle, then publish digits + overflow.
// Ports:
//   clk_in, reset_in   : clock, synchronous active-high reset
//   run_in             : level, keep measuring while 1
//   signal_in          : asynchronous measured signal
//   cnt_reset_out      : counter reset (high in IDLE and CLEAR)
//   cnt_enable_out     : one-cycle pulse per counted edge, only during GATE
//   cnt_digits_in      : counter BCD digits, digit 0 = LSD
//   cnt_carry_in       : counter carry/wrap indication
//   res                : result bundle (digits, overflow, valid, ack)
//   busy               : 1 whenever the FSM is not in IDLE
//   state_dbg_o        : current FSM state encoding
module freq_gate_controller #(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 1000000,
  parameter int GATE_W      = $clog2(GATE_CYCLES)
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    run_in,
  input  logic                    signal_in,
  output logic                    cnt_reset_out,
  output logic                    cnt_enable_out,
  input  logic [4*DIGITS_NUM-1:0] cnt_digits_in,
  input  logic                    cnt_carry_in,
  freq_gate_controller_if.master  res,
  output logic                    busy,
  output logic [2:0]              state_dbg_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_GATE    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_PUBLISH = 3'd4
  } state_t;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [GATE_W-1:0]       timer_q, timer_d;
  logic                    s1_q, s2_q, s3_q;
  logic                    ovf_acc_q, ovf_acc_d;
  logic [4*DIGITS_NUM-1:0] digits_q, digits_d;
  logic                    ovf_q, ovf_d;
  logic                    valid_q, valid_d;
  logic                    en_q, en_d;
  logic                    sig_rise;

  // s1/s2 resynchronize; s3 is the previous s2 value for edge detection.
  assign sig_rise = s2_q & ~s3_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      ovf_acc_q <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      s1_q      <= signal_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      ovf_acc_q <= ovf_acc_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      en_q      <= en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ovf_acc_d = ovf_acc_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    // An ack drops valid next cycle unless PUBLISH reloads it below.
    valid_d   = valid_q & ~res.result_ack;

    case (state_q)
      ST_IDLE: begin
        if (run_in) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        timer_d   = '0;
        ovf_acc_d = 1'b0;
        state_d   = ST_GATE;
      end
      ST_GATE: begin
        timer_d = timer_q + 1'b1;
        if (cnt_carry_in) ovf_acc_d = 1'b1;
        if (timer_q == GATE_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Carry from the final GATE increment can still show up here.
        if (cnt_carry_in) ovf_acc_d = 1'b1;
        state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        // Wait while the previous result is still unconsumed.
        if (!(valid_q && !res.result_ack)) begin
          digits_d = cnt_digits_in;
          ovf_d    = ovf_acc_q;
          valid_d  = 1'b1;
          state_d  = run_in ? ST_CLEAR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Gating with the next state keeps every enable pulse inside GATE and
    // drops an edge seen in the last GATE cycle, so nothing leaks over.
    en_d = sig_rise && (state_d == ST_GATE);
  end

  assign cnt_reset_out       = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
  assign cnt_enable_out      = en_q;
  assign busy                = (state_q != ST_IDLE);
  assign state_dbg_o         = state_q;
  assign res.result_digits   = digits_q;
  assign res.result_overflow = ovf_q;
  assign res.result_valid    = valid_q;

endmodule

// File: tb/tb_freq_gate_controller.sv
module tb_freq_gate_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 6-digit instance, GATE_CYCLES = 20
  logic rst6, run6, sig6, cnt_rst6, en6, busy6;
  logic [2:0] st6;
  logic [23:0] cnt6_q;
  logic carry6_q;
  freq_gate_controller_if #(.DIGITS_NUM(6)) r6();

  freq_gate_controller #(.DIGITS_NUM(6), .GATE_CYCLES(20)) u6 (
    .clk_in(clk), .reset_in(rst6), .run_in(run6), .signal_in(sig6),
    .cnt_reset_out(cnt_rst6), .cnt_enable_out(en6),
    .cnt_digits_in(cnt6_q), .cnt_carry_in(carry6_q),
    .res(r6), .busy(busy6), .state_dbg_o(st6)
  );

  // 1-digit instance, GATE_CYCLES = 40
  logic rst1, run1, sig1, cnt_rst1, en1, busy1;
  logic [2:0] st1;
  logic [3:0] cnt1_q;
  logic carry1_q;
  freq_gate_controller_if #(.DIGITS_NUM(1)) r1();

  freq_gate_controller #(.DIGITS_NUM(1), .GATE_CYCLES(40)) u1 (
    .clk_in(clk), .reset_in(rst1), .run_in(run1), .signal_in(sig1),
    .cnt_reset_out(cnt_rst1), .cnt_enable_out(en1),
    .cnt_digits_in(cnt1_q), .cnt_carry_in(carry1_q),
    .res(r1), .busy(busy1), .state_dbg_o(st1)
  );

  // ---------------- attached BCD counter models ----------------
  function automatic logic [23:0] bcd_inc6(input logic [23:0] v);
    logic [23:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (cnt_rst6) begin
      cnt6_q   <= '0;
      carry6_q <= 1'b0;
    end else begin
      carry6_q <= en6 && (cnt6_q == 24'h999999);
      if (en6) cnt6_q <= bcd_inc6(cnt6_q);
    end
  end

  always_ff @(posedge clk) begin
    if (cnt_rst1) begin
      cnt1_q   <= '0;
      carry1_q <= 1'b0;
    end else begin
      carry1_q <= en1 && (cnt1_q == 4'd9);
      if (en1) cnt1_q <= (cnt1_q == 4'd9) ? 4'd0 : cnt1_q + 4'd1;
    end
  end

  // ---------------- scoreboard counters / check ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Signal generators: period 0 means signal driven directly by the sequence.
  int per6 = 0, ph6 = 0, per1 = 0, ph1 = 0;

  task automatic tick();
    @(negedge clk);
    if (per6 != 0) begin
      ph6  = (ph6 + 1) % per6;
      sig6 = (ph6 < per6 / 2);
    end
    if (per1 != 0) begin
      ph1  = (ph1 + 1) % per1;
      sig1 = (ph1 < per1 / 2);
    end
  endtask

  task automatic wait_valid6(input string tag, input int budget, output int n);
    n = 0;
    while (r6.result_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, r6.result_valid}, 32'd1);
  endtask

  task automatic wait_valid1(input string tag, input int budget, output int n);
    n = 0;
    while (r1.result_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, r1.result_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- sequence ----------------
  initial begin
    int n;
    rst6 = 1'b1; run6 = 1'b0; sig6 = 1'b0; r6.result_ack = 1'b0;
    rst1 = 1'b1; run1 = 1'b0; sig1 = 1'b0; r1.result_ack = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_cnt_reset", {31'd0, cnt_rst6}, 32'd1);
    check("rst_enable",    {31'd0, en6}, 32'd0);
    check("rst_busy",      {31'd0, busy6}, 32'd0);
    check("rst_valid",     {31'd0, r6.result_valid}, 32'd0);
    check("rst_digits",    {8'd0, r6.result_digits}, 32'd0);
    check("rst_ovf",       {31'd0, r6.result_overflow}, 32'd0);
    check("rst_state",     {29'd0, st6}, 32'd0);
    check("rst1_valid",    {31'd0, r1.result_valid}, 32'd0);

    // Basic count: rise every 4 cycles -> 5 edges per 20-cycle window
    rst6 = 1'b0; run6 = 1'b1;
    per6 = 4; ph6 = 0; sig6 = 1'b1;
    wait_valid6("basic_valid", 80, n);
    check("basic_digits", {8'd0, r6.result_digits}, 32'h000005);
    check("basic_ovf",    {31'd0, r6.result_overflow}, 32'd0);
    check("basic_clear_reset", {31'd0, cnt_rst6}, 32'd1);
    tick();
    check("basic_gate_reset", {31'd0, cnt_rst6}, 32'd0);
    check("basic_busy",       {31'd0, busy6}, 32'd1);
    check("basic_hold_valid", {31'd0, r6.result_valid}, 32'd1);
    tick();
    r6.result_ack = 1'b1;
    check("basic_valid_ack_cycle", {31'd0, r6.result_valid}, 32'd1);
    check("basic_hold_digits", {8'd0, r6.result_digits}, 32'h000005);
    tick();
    r6.result_ack = 1'b0;
    check("basic_valid_drop", {31'd0, r6.result_valid}, 32'd0);

    // Window spacing: next result GATE_CYCLES+3 after the previous one
    wait_valid6("spacing_valid", 40, n);
    check("spacing_cycles", n, 32'd20);
    check("spacing_digits", {8'd0, r6.result_digits}, 32'h000005);

    // Stop mid-GATE: measurement completes, FSM parks in IDLE
    r6.result_ack = 1'b1;
    tick();
    r6.result_ack = 1'b0;
    check("stop_ack_drop", {31'd0, r6.result_valid}, 32'd0);
    repeat (5) tick();
    check("stop_in_gate", {29'd0, st6}, 32'd2);
    run6 = 1'b0;
    wait_valid6("stop_valid", 40, n);
    check("stop_cycles",    n, 32'd17);
    check("stop_digits",    {8'd0, r6.result_digits}, 32'h000005);
    check("stop_state",     {29'd0, st6}, 32'd0);
    check("stop_cnt_reset", {31'd0, cnt_rst6}, 32'd1);
    check("stop_busy",      {31'd0, busy6}, 32'd0);
    repeat (5) tick();
    check("stop_idle_valid", {31'd0, r6.result_valid}, 32'd1);
    check("stop_idle_state", {29'd0, st6}, 32'd0);

    // Reset mid-GATE with a pending result
    run6 = 1'b1;
    repeat (4) tick();
    check("mrst_in_gate", {29'd0, st6}, 32'd2);
    rst6 = 1'b1;
    tick();
    check("mrst_valid",     {31'd0, r6.result_valid}, 32'd0);
    check("mrst_digits",    {8'd0, r6.result_digits}, 32'd0);
    check("mrst_ovf",       {31'd0, r6.result_overflow}, 32'd0);
    check("mrst_busy",      {31'd0, busy6}, 32'd0);
    check("mrst_cnt_reset", {31'd0, cnt_rst6}, 32'd1);
    check("mrst_enable",    {31'd0, en6}, 32'd0);
    check("mrst_state",     {29'd0, st6}, 32'd0);

    // Gate edge: stuck low, then a late pulse (dropped), then one just in time
    per6 = 0; sig6 = 1'b0; run6 = 1'b0;
    tick();
    rst6 = 1'b0; run6 = 1'b1;
    wait_valid6("edge_low_valid", 80, n);
    check("edge_low_digits", {8'd0, r6.result_digits}, 32'd0);
    r6.result_ack = 1'b1;
    tick();
    r6.result_ack = 1'b0;
    repeat (17) tick();
    sig6 = 1'b1;
    tick();
    sig6 = 1'b0;
    wait_valid6("edge_late_valid", 40, n);
    check("edge_late_digits", {8'd0, r6.result_digits}, 32'd0);
    r6.result_ack = 1'b1;
    tick();
    r6.result_ack = 1'b0;
    repeat (16) tick();
    sig6 = 1'b1;
    tick();
    sig6 = 1'b0;
    wait_valid6("edge_last_valid", 40, n);
    check("edge_last_digits", {8'd0, r6.result_digits}, 32'd1);
    r6.result_ack = 1'b1;
    tick();
    r6.result_ack = 1'b0;

    // Backpressure: first result 0, second window counts 5, held in PUBLISH
    rst6 = 1'b1; run6 = 1'b0;
    repeat (2) tick();
    rst6 = 1'b0; run6 = 1'b1;
    wait_valid6("bp_first_valid", 80, n);
    check("bp_first_digits", {8'd0, r6.result_digits}, 32'd0);
    per6 = 4; ph6 = 0; sig6 = 1'b1;
    repeat (30) tick();
    check("bp_hold_state",  {29'd0, st6}, 32'd4);
    check("bp_hold_busy",   {31'd0, busy6}, 32'd1);
    check("bp_hold_digits", {8'd0, r6.result_digits}, 32'd0);
    repeat (25) tick();
    check("bp_hold2_state",  {29'd0, st6}, 32'd4);
    check("bp_hold2_digits", {8'd0, r6.result_digits}, 32'd0);
    check("bp_hold2_valid",  {31'd0, r6.result_valid}, 32'd1);
    r6.result_ack = 1'b1;
    tick();
    r6.result_ack = 1'b0;
    check("bp_new_valid",  {31'd0, r6.result_valid}, 32'd1);
    check("bp_new_digits", {8'd0, r6.result_digits}, 32'h000005);
    check("bp_new_state",  {29'd0, st6}, 32'd1);
    tick();
    check("bp_after_valid", {31'd0, r6.result_valid}, 32'd1);

    // Overflow: 1 digit, 40-cycle gate, 20 edges -> digit 0 with overflow
    rst1 = 1'b0; run1 = 1'b1;
    per1 = 2; ph1 = 0; sig1 = 1'b1;
    wait_valid1("ovf_valid", 120, n);
    check("ovf_digit", {28'd0, r1.result_digits}, 32'd0);
    check("ovf_flag",  {31'd0, r1.result_overflow}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
